// File: rtl/pong_game_ctrl.sv
// Pong match controller: BCD scores, last-point indicator, game-state FSM and
// registered region/freeze decode for the text overlay stage.
module pong_game_ctrl #(
  parameter int         WAIT_CYCLES = 200_000_000,
  parameter logic [7:0] WIN_BCD     = 8'h11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       p1_point,
  input  logic       p2_point,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic [1:0] ball,
  output logic [1:0] game_state,
  output logic       graph_still,
  output logic [3:0] text_en
);

  localparam int TW = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_NEWGAME = 2'b00,
    S_PLAY    = 2'b01,
    S_NEWBALL = 2'b10,
    S_OVER    = 2'b11
  } state_t;

  state_t        state_reg, state_next;
  logic [7:0]    p1_reg, p1_next;
  logic [7:0]    p2_reg, p2_next;
  logic [1:0]    ball_reg, ball_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic          btn_q_reg;
  logic          graph_still_reg, graph_still_next;
  logic [3:0]    text_en_reg, text_en_next;
  logic          start_rise;

  // Two-digit BCD increment; 99 is a hard ceiling.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (v == 8'h99)
      r = v;
    else if (v[3:0] >= 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  assign start_rise = btn_start & ~btn_q_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg       <= S_NEWGAME;
      p1_reg          <= 8'h00;
      p2_reg          <= 8'h00;
      ball_reg        <= 2'b00;
      timer_reg       <= '0;
      btn_q_reg       <= 1'b0;
      graph_still_reg <= 1'b1;
      text_en_reg     <= 4'b1110;
    end else begin
      state_reg       <= state_next;
      p1_reg          <= p1_next;
      p2_reg          <= p2_next;
      ball_reg        <= ball_next;
      timer_reg       <= timer_next;
      btn_q_reg       <= btn_start;
      graph_still_reg <= graph_still_next;
      text_en_reg     <= text_en_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    p1_next    = p1_reg;
    p2_next    = p2_reg;
    ball_next  = ball_reg;
    timer_next = timer_reg;
    case (state_reg)
      S_NEWGAME: begin
        if (start_rise) begin
          p1_next    = 8'h00;
          p2_next    = 8'h00;
          ball_next  = 2'b00;
          state_next = S_PLAY;
        end
      end
      S_PLAY: begin
        if (p1_point || p2_point) begin
          if (p1_point && p2_point) begin
            ball_next = 2'b11;
          end else if (p1_point) begin
            p1_next   = bcd_inc(p1_reg);
            ball_next = 2'b01;
          end else begin
            p2_next   = bcd_inc(p2_reg);
            ball_next = 2'b10;
          end
          timer_next = TIMER_LOAD;
          // Win check on the post-increment score so the deciding point skips NEWBALL.
          if (p1_next == WIN_BCD || p2_next == WIN_BCD)
            state_next = S_OVER;
          else
            state_next = S_NEWBALL;
        end
      end
      S_NEWBALL: begin
        if (timer_reg != '0)
          timer_next = timer_reg - TW'(1);
        else if (!btn_start)
          state_next = S_PLAY;
      end
      S_OVER: begin
        if (timer_reg != '0)
          timer_next = timer_reg - TW'(1);
        else
          state_next = S_NEWGAME;
      end
      default: state_next = S_NEWGAME;
    endcase
  end

  // Overlay decode is computed from the next state so it lines up with game_state.
  always_comb begin
    graph_still_next = (state_next != S_PLAY);
    text_en_next     = 4'b1110;
    case (state_next)
      S_NEWGAME: text_en_next = 4'b1110;
      S_PLAY:    text_en_next = 4'b1000;
      S_NEWBALL: text_en_next = 4'b1000;
      S_OVER:    text_en_next = 4'b1001;
      default:   text_en_next = 4'b1110;
    endcase
  end

  assign dig0        = p1_reg[3:0];
  assign dig1        = p1_reg[7:4];
  assign dig2        = p2_reg[3:0];
  assign dig3        = p2_reg[7:4];
  assign ball        = ball_reg;
  assign game_state  = state_reg;
  assign graph_still = graph_still_reg;
  assign text_en     = text_en_reg;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: stimulus queues expected snapshots
// tagged with a cycle number; a negedge monitor pops and compares them.
module tb_pong_game_ctrl;

  localparam int         WAIT = 10;
  localparam logic [7:0] WIN  = 8'h11;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_start = 1'b0;
  logic       p1_point = 1'b0;
  logic       p2_point = 1'b0;
  logic [3:0] dig0, dig1, dig2, dig3;
  logic [1:0] ball, game_state;
  logic       graph_still;
  logic [3:0] text_en;

  pong_game_ctrl #(.WAIT_CYCLES(WAIT), .WIN_BCD(WIN)) dut (
    .clk(clk), .reset(reset), .btn_start(btn_start),
    .p1_point(p1_point), .p2_point(p2_point),
    .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
    .ball(ball), .game_state(game_state),
    .graph_still(graph_still), .text_en(text_en)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string      name;
    int         at;
    logic [15:0] digs;
    logic [1:0] ball;
    logic [1:0] st;
    logic       gs;
    logic [3:0] te;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  // Queue an expectation for the state visible after the next rising edge.
  task automatic chk(input string name, input logic [15:0] digs,
                     input logic [1:0] b, input logic [1:0] st);
    exp_t e;
    e.name = name;
    e.at   = cyc + 1;
    e.digs = digs;
    e.ball = b;
    e.st   = st;
    e.gs   = (st != 2'b01);
    case (st)
      2'b00:   e.te = 4'b1110;
      2'b11:   e.te = 4'b1001;
      default: e.te = 4'b1000;
    endcase
    q.push_back(e);
  endtask

  task automatic step(input logic rstn, input logic b, input logic p1, input logic p2);
    @(posedge clk);
    #1;
    reset     = rstn;
    btn_start = b;
    p1_point  = p1;
    p2_point  = p2;
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].at <= cyc) begin
      exp_t e;
      logic [15:0] ad;
      e  = q.pop_front();
      ad = {dig3, dig2, dig1, dig0};
      tests++;
      if (e.at < cyc) begin
        fails++;
        $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.name, e.at, cyc);
      end else if (ad !== e.digs || ball !== e.ball || game_state !== e.st ||
                   graph_still !== e.gs || text_en !== e.te) begin
        fails++;
        $display("FAIL %s: got digs=%h ball=%b st=%b still=%b text=%b, want digs=%h ball=%b st=%b still=%b text=%b",
                 e.name, ad, ball, game_state, graph_still, text_en,
                 e.digs, e.ball, e.st, e.gs, e.te);
      end else begin
        $display("[TB] cyc %0d %s ok: digs=%h ball=%b st=%b", cyc, e.name, ad, ball, game_state);
      end
    end
  end

  // Ride out a NEWBALL pause after a point at edge n; PLAY appears after edge n+WAIT.
  task automatic serve(input string name, input logic [15:0] digs, input logic [1:0] b);
    for (int i = 1; i <= WAIT; i++) begin
      step(1, 0, 0, 0);
      if (i == WAIT - 1) chk({name, " still newball"}, digs, b, 2'b10);
      if (i == WAIT)     chk({name, " serve"}, digs, b, 2'b01);
    end
  endtask

  initial begin
    logic [15:0] d;
    step(0, 0, 0, 0); chk("reset", 16'h0000, 2'b00, 2'b00);
    step(1, 0, 0, 0); chk("idle newgame", 16'h0000, 2'b00, 2'b00);
    step(1, 0, 1, 0); chk("p1 in newgame ignored", 16'h0000, 2'b00, 2'b00);
    step(1, 1, 0, 0); chk("start", 16'h0000, 2'b00, 2'b01);
    step(1, 1, 0, 0); chk("start held", 16'h0000, 2'b00, 2'b01);
    step(1, 0, 0, 0); chk("start released", 16'h0000, 2'b00, 2'b01);

    step(1, 0, 1, 0); chk("p1 point", 16'h0001, 2'b01, 2'b10);
    step(1, 0, 0, 1); chk("p2 in newball ignored", 16'h0001, 2'b01, 2'b10);
    for (int i = 2; i <= WAIT; i++) begin
      step(1, 0, 0, 0);
      if (i == WAIT - 1) chk("pause not done", 16'h0001, 2'b01, 2'b10);
      if (i == WAIT)     chk("pause done", 16'h0001, 2'b01, 2'b01);
    end

    // Reset while the NEWBALL timer holds 5.
    step(1, 0, 0, 1); chk("p2 point", 16'h0101, 2'b10, 2'b10);
    for (int i = 1; i <= 4; i++) step(1, 0, 0, 0);
    step(0, 0, 0, 0); chk("reset mid newball", 16'h0000, 2'b00, 2'b00);
    step(1, 0, 0, 0); chk("after reset", 16'h0000, 2'b00, 2'b00);
    step(1, 1, 0, 0); chk("restart", 16'h0000, 2'b00, 2'b01);
    step(1, 0, 0, 0); chk("restart released", 16'h0000, 2'b00, 2'b01);

    step(1, 0, 1, 1); chk("simultaneous", 16'h0000, 2'b11, 2'b10);
    serve("sim", 16'h0000, 2'b11);

    // Button held across NEWBALL expiry must not serve.
    step(1, 0, 1, 0); chk("p1 before hold", 16'h0001, 2'b01, 2'b10);
    for (int i = 1; i <= WAIT + 1; i++) begin
      step(1, 1, 0, 0);
      if (i == WAIT)     chk("held at expiry", 16'h0001, 2'b01, 2'b10);
      if (i == WAIT + 1) chk("held past expiry", 16'h0001, 2'b01, 2'b10);
    end
    step(1, 0, 0, 0); chk("released serves", 16'h0001, 2'b01, 2'b01);

    for (int k = 1; k <= 10; k++) begin
      d = {4'(k / 10), 4'(k % 10), 8'h01};
      step(1, 0, 0, 1); chk((k == 10) ? "p2 bcd carry" : "p2 point", d, 2'b10, 2'b10);
      serve("p2", d, 2'b10);
    end

    step(1, 0, 0, 1); chk("p2 wins", 16'h1101, 2'b10, 2'b11);
    step(1, 0, 1, 1); chk("points in over ignored", 16'h1101, 2'b10, 2'b11);
    for (int i = 2; i <= WAIT; i++) begin
      step(1, 0, 0, 0);
      if (i == WAIT - 1) chk("over pause", 16'h1101, 2'b10, 2'b11);
      if (i == WAIT)     chk("over to newgame", 16'h1101, 2'b10, 2'b00);
    end
    step(1, 0, 1, 0); chk("score retained", 16'h1101, 2'b10, 2'b00);
    step(1, 1, 0, 0); chk("fresh start clears", 16'h0000, 2'b00, 2'b01);
    step(1, 1, 0, 0); chk("fresh start held", 16'h0000, 2'b00, 2'b01);

    repeat (3) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
